// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one zero-latency word memory between the fetch and load/store ports.
// Data has priority unless fetch has been starved for STARVE_LIMIT cycles.
module imem_dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_write,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_write,
    output logic                    mem_read,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [31:0]             conflict_cnt
);

    localparam int unsigned SC_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_WIDTH-1:0] STARVE_LAST = SC_WIDTH'(STARVE_LIMIT - 1);
    localparam logic [SC_WIDTH-1:0] STARVE_MAX  = SC_WIDTH'(STARVE_LIMIT);

    typedef enum logic {
        DATA_PRI  = 1'b0,
        FETCH_PRI = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SC_WIDTH-1:0] starve_cnt, starve_d;
    logic                d_load_gnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DATA_PRI;
            starve_cnt <= '0;
        end else begin
            state_q    <= state_d;
            starve_cnt <= starve_d;
        end
    end

    // Grant selection, memory drive and next-state logic
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_cnt;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;

        if (!rst) begin
            if (state_q == DATA_PRI) begin
                d_gnt  = d_req;
                if_gnt = if_req && !d_req;
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req && !if_req;
            end
        end

        if (if_gnt) begin
            mem_addr = if_addr;
            mem_read = 1'b1;
        end else if (d_gnt) begin
            mem_addr = d_addr;
            if (d_write) begin
                mem_wdata = d_wdata;
                mem_wstrb = d_wstrb;
                mem_write = 1'b1;
            end else begin
                mem_read = 1'b1;
            end
        end

        if (if_req && !if_gnt) begin
            if (starve_cnt != STARVE_MAX) starve_d = starve_cnt + SC_WIDTH'(1);
        end else begin
            starve_d = '0;
        end

        // Priority flips for exactly one fetch grant, then falls back to data
        case (state_q)
            DATA_PRI: begin
                if (if_req && !if_gnt && starve_cnt == STARVE_LAST) begin
                    state_d  = FETCH_PRI;
                    starve_d = '0;
                end
            end
            FETCH_PRI: begin
                if (if_gnt || !if_req) begin
                    state_d  = DATA_PRI;
                    starve_d = '0;
                end
            end
            default: state_d = DATA_PRI;
        endcase
    end

    assign d_load_gnt = d_gnt && !d_write;

    // Registered read return and contention statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid    <= 1'b0;
            d_rvalid     <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            conflict_cnt <= '0;
        end else begin
            if_rvalid <= if_gnt;
            d_rvalid  <= d_load_gnt;
            if (if_gnt)     if_rdata <= mem_rdata;
            if (d_load_gnt) d_rdata  <= mem_rdata;
            if (if_req && d_req && conflict_cnt != 32'hFFFF_FFFF)
                conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a small byte-strobed memory model
// and per-port read-data scoreboards.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic [31:0] conflict_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];

    logic [31:0] mem_arr [0:63];
    logic        loaded = 1'b0;

    imem_dmem_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_wstrb     (d_wstrb),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_rdata   (mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Zero-latency memory model: preloaded on the first edge, byte-strobed writes
    assign mem_rdata = mem_read ? mem_arr[mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= 32'h0;
            mem_arr[4]  <= 32'h0000_0013;
            mem_arr[17] <= 32'h1234_5678;
            loaded      <= 1'b1;
        end else if (mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem_arr[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven; check grants/memory drive, then the response
    task automatic step(input logic e_if, input logic e_d, input logic [31:0] e_data, input string tag);
        logic        e_st;
        logic        e_ld;
        logic [31:0] e_addr;
        e_st   = e_d && d_write;
        e_ld   = e_d && !d_write;
        e_addr = e_if ? if_addr : (e_d ? d_addr : 32'h0);
        #1;
        chk({tag, ":if_gnt"},    32'(if_gnt),    32'(e_if));
        chk({tag, ":d_gnt"},     32'(d_gnt),     32'(e_d));
        chk({tag, ":mem_addr"},  mem_addr,       e_addr);
        chk({tag, ":mem_read"},  32'(mem_read),  32'(e_if || e_ld));
        chk({tag, ":mem_write"}, 32'(mem_write), 32'(e_st));
        if (!e_ld) begin
            chk({tag, ":mem_wdata"}, mem_wdata,       e_st ? d_wdata : 32'h0);
            chk({tag, ":mem_wstrb"}, 32'(mem_wstrb),  e_st ? 32'(d_wstrb) : 32'h0);
        end
        if (e_if) if_q.push_back(e_data);
        if (e_ld) d_q.push_back(e_data);
        @(posedge clk);
        #1;
        chk({tag, ":if_rvalid"}, 32'(if_rvalid), 32'(e_if));
        chk({tag, ":d_rvalid"},  32'(d_rvalid),  32'(e_ld));
        if (if_rvalid && if_q.size() != 0) chk({tag, ":if_rdata"}, if_rdata, if_q.pop_front());
        if (d_rvalid && d_q.size() != 0)   chk({tag, ":d_rdata"},  d_rdata,  d_q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h40; d_wdata = 32'h0; d_wstrb = 4'h0;
        @(negedge clk);

        // Reset: grants forced low even with both requests up
        step(1'b0, 1'b0, 32'h0, "rst0");
        step(1'b0, 1'b0, 32'h0, "rst1");
        chk("rst:conflict_cnt", conflict_cnt, 32'h0);
        chk("rst:if_rdata", if_rdata, 32'h0);
        chk("rst:d_rdata", d_rdata, 32'h0);
        chk("rst:state", 32'(dut.state_q), 32'h0);

        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;

        // Fetch only
        if_req = 1'b1; if_addr = 32'h10;
        step(1'b1, 1'b0, 32'h0000_0013, "fetch");
        if_req = 1'b0;
        step(1'b0, 1'b0, 32'h0, "idle0");

        // Full store, then load it back
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        step(1'b0, 1'b1, 32'h0, "store");
        d_write = 1'b0; d_wdata = 32'h0; d_wstrb = 4'h0;
        step(1'b0, 1'b1, 32'hDEAD_BEEF, "load40");

        // Partial store merges into preloaded 0x12345678
        d_write = 1'b1; d_addr = 32'h44; d_wdata = 32'h0000_BEEF; d_wstrb = 4'h3;
        step(1'b0, 1'b1, 32'h0, "pstore");
        d_write = 1'b0; d_wdata = 32'h0; d_wstrb = 4'h0;
        step(1'b0, 1'b1, 32'h1234_BEEF, "load44");
        d_req = 1'b0;
        step(1'b0, 1'b0, 32'h0, "idle1");

        // Continuous contention: fetch wins on cycles 4 and 9
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_addr = 32'h40;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) step(1'b1, 1'b0, 32'h0000_0013, "contend_if");
            else                  step(1'b0, 1'b1, 32'hDEAD_BEEF, "contend_d");
        end
        chk("contend:conflict_cnt", conflict_cnt, 32'd10);

        // Withdrawal from FETCH_PRI
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hDEAD_BEEF, "starve");
        chk("starve:state", 32'(dut.state_q), 32'h1);
        if_req = 1'b0;
        step(1'b0, 1'b1, 32'hDEAD_BEEF, "withdraw");
        chk("withdraw:state", 32'(dut.state_q), 32'h0);
        chk("withdraw:starve_cnt", 32'(dut.starve_cnt), 32'h0);
        if_req = 1'b1;
        step(1'b0, 1'b1, 32'hDEAD_BEEF, "after_withdraw");
        chk("withdraw:conflict_cnt", conflict_cnt, 32'd15);

        // Reset mid-operation
        d_req = 1'b0;
        step(1'b1, 1'b0, 32'h0000_0013, "pre_rst_fetch");
        rst = 1'b1; d_req = 1'b1;
        step(1'b0, 1'b0, 32'h0, "mid_rst");
        chk("mid_rst:if_rdata", if_rdata, 32'h0);
        chk("mid_rst:d_rdata", d_rdata, 32'h0);
        chk("mid_rst:conflict_cnt", conflict_cnt, 32'h0);
        chk("mid_rst:state", 32'(dut.state_q), 32'h0);
        chk("mid_rst:starve_cnt", 32'(dut.starve_cnt), 32'h0);
        rst = 1'b0;
        step(1'b0, 1'b1, 32'hDEAD_BEEF, "post_rst");
        if_req = 1'b0; d_req = 1'b0;
        step(1'b0, 1'b0, 32'h0, "drain");
        chk("end:conflict_cnt", conflict_cnt, 32'd1);
        chk("end:if_q_left", 32'(if_q.size()), 32'h0);
        chk("end:d_q_left", 32'(d_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview: Shares one zero-latency word memory (mem_zerolat) between the core's instruction-fetch port and its load/store port, so a unified imem/dmem image can run. The data port has priority by default. A starvation counter forces a fetch grant after STARVE_LIMIT consecutive denials. Read data is registered and returned one cycle after grant with a per-port rvalid. The block sits between single_cycle_core (fetch side stalls on !if_gnt) and a single mem_zerolat instance.

Parameters:
ADDR_WIDTH, 32, byte-address width of all address ports
DATA_WIDTH, 32, data word width; strobe width is DATA_WIDTH/8
STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch gets priority (legal range >=1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch read request; held with stable if_addr until if_gnt
if_addr  in  ADDR_WIDTH  fetch byte address
if_gnt  out  1  fetch granted this cycle (combinational)
if_rvalid  out  1  if_rdata valid; registered, one cycle after if_gnt
if_rdata  out  DATA_WIDTH  registered fetch data
d_req  in  1  data request; held with stable payload until d_gnt
d_write  in  1  1 = store, 0 = load
d_addr  in  ADDR_WIDTH  data byte address
d_wdata  in  DATA_WIDTH  store data
d_wstrb  in  DATA_WIDTH/8  store byte enables
d_gnt  out  1  data granted this cycle (combinational)
d_rvalid  out  1  d_rdata valid one cycle after a granted load; never for stores
d_rdata  out  DATA_WIDTH  registered load data
mem_addr  out  ADDR_WIDTH  byte address to memory
mem_wdata  out  DATA_WIDTH  write data to memory
mem_wstrb  out  DATA_WIDTH/8  byte enables to memory
mem_write  out  1  memory write enable
mem_read  out  1  memory read enable
mem_rdata  in  DATA_WIDTH  memory read data, valid in the same cycle
conflict_cnt  out  32  cycles with if_req and d_req both high; saturates at 0xFFFFFFFF

Behaviour:
- Reset, when rst is high at an edge: if_rvalid, d_rvalid, if_rdata, d_rdata and conflict_cnt all go to 0. The state machine enters DATA_PRI and starve_cnt goes to 0. Any pending rvalid is dropped.
- While rst is high, if_gnt, d_gnt, mem_read and mem_write are forced to 0.
- States are DATA_PRI and FETCH_PRI.
  - DATA_PRI: d_req wins if asserted, otherwise if_req wins.
  - FETCH_PRI: if_req wins if asserted, otherwise d_req wins.
- At most one grant per cycle. A grant requires its req to be high.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - increments on each cycle with if_req high and if_gnt low;
  - clears on if_gnt or when if_req is low.
- DATA_PRI -> FETCH_PRI at an edge where if_req is high, if_gnt is low and starve_cnt == STARVE_LIMIT-1.
- FETCH_PRI -> DATA_PRI at an edge with if_gnt high, or with if_req low (request withdrawn). starve_cnt clears on either transition.
- Memory drive in the grant cycle:
  - Fetch grant: mem_addr = if_addr, mem_read = 1, mem_write = 0, mem_wdata = 0, mem_wstrb = 0.
  - Data load grant: mem_addr = d_addr, mem_read = 1, mem_write = 0.
  - Data store grant: mem_addr = d_addr, mem_wdata = d_wdata, mem_wstrb = d_wstrb, mem_write = 1, mem_read = 0.
  - No grant: all mem outputs are 0.
- Read latency:
  - Granted fetch: if_rdata <= mem_rdata and if_rvalid = 1 at the next edge.
  - Granted load: d_rdata <= mem_rdata and d_rvalid = 1 at the next edge.
  - rvalid is a single-cycle pulse. The rdata registers hold their value until the next granted read on that port.
- Simultaneous events: a new request may be granted in the same cycle that the previous response's rvalid is high (full throughput, one access per cycle).
- conflict_cnt increments on every cycle with both reqs high, regardless of grant outcome, and stops at all-ones.
- A requester that drops req without a grant causes no memory access.
- Address width: mem_addr carries the full byte address. Word selection (addr[clog2(DEPTH)+1:2]) is the memory-side wrapper's job.

Test Plan:
- Fetch only: mem word at 0x10 = 0x00000013, if_req=1, if_addr=0x10 -> if_gnt=1 and mem_read=1 that cycle; next cycle if_rvalid=1, if_rdata=0x00000013; d_rvalid stays 0.
- Store then load: d_write=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_wstrb=0xF -> mem_write=1 for 1 cycle, d_rvalid stays 0. Then load 0x40 -> d_rvalid=1, d_rdata=0xDEADBEEF one cycle later.
- Partial store: d_wstrb=0x3, d_wdata=0x0000BEEF at 0x44 -> mem_wstrb=0x3, mem_wdata=0x0000BEEF in the grant cycle.
- Continuous contention, STARVE_LIMIT=4, both reqs held for 10 cycles -> d_gnt in cycles 0-3, if_gnt in cycle 4, d_gnt in cycles 5-8, if_gnt in cycle 9; conflict_cnt=10 afterwards.
- Withdrawal: reach FETCH_PRI, then drop if_req with d_req held -> d_gnt continues, state returns to DATA_PRI, starve_cnt=0.
- Reset mid-operation: fetch granted in cycle N, rst=1 at edge N+1 -> if_rvalid=0 and if_rdata=0 after that edge, conflict_cnt=0, and the first post-reset contention goes to the data port.
